// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the sprite motion logic.
package game_pkg;
    typedef enum logic [1:0] {GROUNDED, JUMP, FALL, LAND} state_t;
    localparam int COUNT_W = 11;
    localparam int VEL_W = 10;
    localparam logic [COUNT_W-1:0] GRAV_LOAD = 11'd340;
endpackage

// File: rtl/jump_buf.sv
// jump_buf: jump-key edge detect with a frame-counted press buffer.
module jump_buf import game_pkg::*; #(
    parameter int BUF_FRAMES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic jump_key,
    input  logic frame_tick,
    input  logic take,
    output logic pending
);
    localparam int CW = $clog2(BUF_FRAMES + 1);
    logic key_q, pend_q, pend_d, press;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        press = jump_key & ~key_q;
        pend_d = press ? 1'b1 : (take || (frame_tick && pend_q && cnt_q == CW'(1))) ? 1'b0 : pend_q;
        cnt_d = press ? CW'(BUF_FRAMES) : (frame_tick && pend_q) ? cnt_q - CW'(1) : cnt_q;
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_q <= 1'b0;
            pend_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            key_q <= jump_key;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
        end
    end
    assign pending = pend_q;
endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl: grounded/jump/fall controller driving the gravity counter
// and turning its Count into a signed per-frame vertical velocity.
module jump_ctrl import game_pkg::*; #(
    parameter int JUMP_V = 10,
    parameter int VEL_SHIFT = 5,
    parameter int MAX_FALL = 12,
    parameter int BUF_FRAMES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic frame_tick,
    input  logic jump_key,
    input  logic on_ground,
    input  logic head_hit,
    input  logic [COUNT_W-1:0] Count,
    output logic count_en,
    output logic pure_grav,
    output logic count_rst,
    output logic signed [VEL_W-1:0] y_vel,
    output logic in_air,
    output logic land_pulse
);
    localparam logic signed [COUNT_W-1:0] JV = COUNT_W'(JUMP_V);
    localparam logic signed [COUNT_W-1:0] VMAX = COUNT_W'(MAX_FALL);
    localparam logic [COUNT_W-1:0] COUNT_HOLD = COUNT_W'((JUMP_V + MAX_FALL) << VEL_SHIFT);
    state_t state_q, state_d;
    logic pending, take, cnt_en, grav_ld;
    logic signed [COUNT_W-1:0] v_raw, v;
    jump_buf #(.BUF_FRAMES(BUF_FRAMES)) u_buf (
        .CLK(CLK),
        .RESET(RESET),
        .jump_key(jump_key),
        .frame_tick(frame_tick),
        .take(take),
        .pending(pending)
    );
    assign v_raw = $signed(Count >> VEL_SHIFT) - JV;
    assign v = (v_raw > VMAX) ? VMAX : v_raw;
    // Counter controls are Mealy so the counter moves on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_en = 1'b0;
        grav_ld = 1'b0;
        take = 1'b0;
        case (state_q)
            GROUNDED: begin
                if (frame_tick && pending) begin
                    state_d = JUMP;
                    take = 1'b1;
                end else if (frame_tick && !on_ground) begin
                    state_d = FALL;
                    cnt_en = 1'b1;
                    grav_ld = 1'b1;
                end
            end
            JUMP: begin
                cnt_en = frame_tick;
                if (frame_tick && head_hit) begin
                    state_d = FALL;
                    grav_ld = 1'b1;
                end else if (!v[COUNT_W-1]) begin
                    state_d = FALL;
                end
            end
            FALL: begin
                cnt_en = frame_tick && !on_ground && (Count < COUNT_HOLD);
                if (frame_tick && on_ground) state_d = LAND;
            end
            default: state_d = GROUNDED;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= GROUNDED;
        else state_q <= state_d;
    end
    assign count_en = cnt_en & ~RESET;
    assign pure_grav = grav_ld & ~RESET;
    assign count_rst = ~count_en & (state_q == GROUNDED || state_q == LAND);
    assign in_air = (state_q == JUMP) || (state_q == FALL);
    assign land_pulse = (state_q == LAND);
    assign y_vel = in_air ? v[VEL_W-1:0] : '0;
endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl: directed checks of jump_ctrl driving a behavioural gravity counter.
module tb_jump_ctrl;
    import game_pkg::*;
    logic CLK = 1'b0, RESET = 1'b1, frame_tick = 1'b0, jump_key = 1'b0, on_ground = 1'b1, head_hit = 1'b0;
    logic [COUNT_W-1:0] Count = '0;
    logic count_en, pure_grav, count_rst, in_air, land_pulse, en_seen;
    logic signed [VEL_W-1:0] y_vel;
    int total = 0, bad = 0;
    jump_ctrl dut (
        .CLK(CLK),
        .RESET(RESET),
        .frame_tick(frame_tick),
        .jump_key(jump_key),
        .on_ground(on_ground),
        .head_hit(head_hit),
        .Count(Count),
        .count_en(count_en),
        .pure_grav(pure_grav),
        .count_rst(count_rst),
        .y_vel(y_vel),
        .in_air(in_air),
        .land_pulse(land_pulse)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) begin
        if (count_rst) Count <= '0;
        else if (count_en) Count <= pure_grav ? 11'd340 : Count + 11'd1;
    end
    task chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task tick();
        @(negedge CLK);
        frame_tick = 1'b1;
        #1 en_seen = en_seen | count_en;
        @(negedge CLK);
        frame_tick = 1'b0;
        repeat (6) @(negedge CLK);
    endtask
    task press();
        @(negedge CLK);
        jump_key = 1'b1;
        @(negedge CLK);
        jump_key = 1'b0;
    endtask
    task land_tick();
        on_ground = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b1;
        #1 chk("land_en", count_en, 0);
        @(negedge CLK);
        frame_tick = 1'b0;
        chk("land_pulse", land_pulse, 1);
        chk("land_rst", count_rst, 1);
        chk("land_air", in_air, 0);
        @(negedge CLK);
        chk("land_pulse_end", land_pulse, 0);
        chk("land_cnt", Count, 0);
        repeat (5) @(negedge CLK);
    endtask
    initial begin
        en_seen = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_crst", count_rst, 1);
        chk("rst_en", count_en, 0);
        chk("rst_pg", pure_grav, 0);
        chk("rst_vel", y_vel, 0);
        chk("rst_air", in_air, 0);
        chk("rst_land", land_pulse, 0);
        chk("rst_cnt", Count, 0);
        RESET = 1'b0;
        // Jump from the ground up to the apex.
        press();
        tick();
        chk("jmp_air", in_air, 1);
        chk("jmp_vel", y_vel, -10);
        chk("jmp_cnt0", Count, 0);
        repeat (32) tick();
        chk("jmp_cnt32", Count, 32);
        chk("jmp_vel32", y_vel, -9);
        for (int i = 0; i < 400 && Count != 320; i++) tick();
        chk("apex_cnt", Count, 320);
        chk("apex_vel", y_vel, 0);
        chk("apex_st", dut.state_q, FALL);
        land_tick();
        // Walk off a ledge into a pure-gravity fall.
        on_ground = 1'b0;
        @(negedge CLK);
        frame_tick = 1'b1;
        #1 chk("walk_en", count_en, 1);
        chk("walk_pg", pure_grav, 1);
        chk("walk_rst", count_rst, 0);
        @(negedge CLK);
        frame_tick = 1'b0;
        chk("walk_cnt", Count, 340);
        chk("walk_vel", y_vel, 0);
        chk("walk_air", in_air, 1);
        repeat (6) @(negedge CLK);
        for (int i = 0; i < 500 && Count != 704; i++) tick();
        chk("term_cnt", Count, 704);
        chk("term_vel", y_vel, 12);
        en_seen = 1'b0;
        repeat (20) tick();
        chk("hold_en", en_seen, 0);
        chk("hold_cnt", Count, 704);
        chk("hold_vel", y_vel, 12);
        // Press two ticks before landing is still live afterwards.
        press();
        tick();
        land_tick();
        tick();
        chk("buf2_air", in_air, 1);
        chk("buf2_vel", y_vel, -10);
        // Ceiling hit while also on ground: ceiling wins.
        for (int i = 0; i < 200 && Count != 100; i++) tick();
        chk("head_vel", y_vel, -7);
        @(negedge CLK);
        frame_tick = 1'b1;
        head_hit = 1'b1;
        #1 chk("head_pg", pure_grav, 1);
        @(negedge CLK);
        frame_tick = 1'b0;
        head_hit = 1'b0;
        on_ground = 1'b0;
        chk("head_cnt", Count, 340);
        chk("head_vel0", y_vel, 0);
        chk("head_st", dut.state_q, FALL);
        repeat (6) @(negedge CLK);
        // Press five ticks before landing has expired.
        press();
        repeat (4) tick();
        land_tick();
        tick();
        chk("buf5_air", in_air, 0);
        chk("buf5_vel", y_vel, 0);
        chk("buf5_cnt", Count, 0);
        // Asynchronous reset in the middle of a jump.
        press();
        tick();
        repeat (3) tick();
        chk("mid_cnt", Count, 3);
        press();
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 chk("arst_air", in_air, 0);
        chk("arst_vel", y_vel, 0);
        chk("arst_crst", count_rst, 1);
        chk("arst_en", count_en, 0);
        chk("arst_land", land_pulse, 0);
        @(negedge CLK);
        @(negedge CLK);
        chk("arst_cnt", Count, 0);
        RESET = 1'b0;
        tick();
        chk("nospur_air", in_air, 0);
        chk("nospur_cnt", Count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Vertical-motion controller for the player sprite; sits on both sides of the gravity counter.
- Upstream of the counter, it drives the counter's count-enable, gravity-load and reset controls.
- Downstream, it consumes the 11-bit Count and produces a signed per-frame vertical velocity for the sprite position logic.
- Owns the grounded/jumping/falling state machine, jump-key edge detection and a short jump buffer.

Parameters:
- JUMP_V, 10: initial upward speed, pixels/frame.
- VEL_SHIFT, 5: Count right-shift giving velocity increment (1 px/frame per 32 counts).
- MAX_FALL, 12: terminal downward speed, pixels/frame.
- BUF_FRAMES, 4: frames a jump press stays pending.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-CLK pulse per video frame.
- jump_key  in  1  jump button level, synchronous to CLK.
- on_ground  in  1  sprite feet touching floor (collision logic).
- head_hit  in  1  sprite head touching ceiling.
- Count  in  11  gravity counter value; bit 10 always 0, value 0..1023.
- count_en  out  1  counter advance/load enable.
- pure_grav  out  1  counter load of GRAV_LOAD (qualified by count_en).
- count_rst  out  1  counter clear; never asserted together with count_en.
- y_vel  out  10  signed velocity, negative = up.
- in_air  out  1  high in JUMP or FALL.
- land_pulse  out  1  one-CLK pulse on landing.

Behaviour:
- Reset (asynchronous):
  - state=GROUNDED; key_q=0; pending=0; buf_cnt=0.
  - Outputs: count_rst=1, count_en=0, pure_grav=0, y_vel=0, in_air=0, land_pulse=0.
- Edge detect and jump buffer:
  - Press = jump_key & ~key_q.
  - A press sets pending and loads buf_cnt=BUF_FRAMES.
  - Each frame_tick decrements buf_cnt while pending; pending clears when buf_cnt reaches 0 or when a jump is taken.
  - A press while pending reloads buf_cnt.
- Velocity (combinational):
  - v = (Count >> VEL_SHIFT) − JUMP_V, computed in 11-bit signed arithmetic.
  - v saturates at +MAX_FALL.
  - y_vel = v in JUMP/FALL; y_vel = 0 in GROUNDED/LAND.
- COUNT_HOLD = (JUMP_V+MAX_FALL) << VEL_SHIFT (704 at defaults).
- GRAV_LOAD = 340; at defaults v=0 there, so a pure-gravity fall starts at apex speed.
- count_en, pure_grav and count_rst are combinational (Mealy) decodes of state and inputs, so the counter updates on the same edge as the state transition.
- GROUNDED: count_rst=1.
  - frame_tick & pending → JUMP; clear pending. The counter is already 0.
  - Else frame_tick & ~on_ground → FALL, with count_en=1 and pure_grav=1 that cycle (counter loads 340).
  - Jump wins over walk-off.
- JUMP: count_en=frame_tick.
  - frame_tick & head_hit → FALL, with pure_grav=1 (velocity snaps to 0).
  - Else when v ≥ 0 → FALL, no load.
- FALL: count_en = frame_tick & (Count < COUNT_HOLD), so Count never wraps mid-air.
  - frame_tick & on_ground → LAND; count_en=0 that cycle.
- LAND: lasts 1 CLK; count_rst=1, land_pulse=1; → GROUNDED.
  - A pending press survives LAND and is taken on the next frame_tick in GROUNDED if not expired.
- Simultaneous events:
  - head_hit and on_ground together in JUMP: head_hit wins.
  - In FALL, on_ground wins over any pending jump (land first).
- Reset mid-operation returns to GROUNDED immediately; count_rst=1 clears the counter on its next edge.

Decomposition:
- Shared package game_pkg:
  - state_t enum {GROUNDED, JUMP, FALL, LAND}.
  - GRAV_LOAD=340, COUNT_W=11, VEL_W=10.
- One sub-module: jump_buf (edge detect + BUF_FRAMES down-counter).
  - Inputs: CLK, RESET, jump_key, frame_tick, take.
  - Output: pending.

Test Plan (bench instantiates jump_ctrl with the counter block, defaults, frame_tick every 8 CLK):
- Press jump while grounded, tick → state JUMP, y_vel=−10. After 32 ticks, Count=32 and y_vel=−9. At Count=320, y_vel=0 and state becomes FALL.
- on_ground=0 while grounded, tick → count_en=pure_grav=1 in the same cycle. Next Count=340, y_vel=0, in_air=1.
- Fall to Count=704 → y_vel=12 and count_en stays 0 on later ticks; Count holds at 704 for 20 more ticks, with no wrap.
- head_hit at Count=100 in JUMP (y_vel=−7) → FALL; Count=340, y_vel=0.
- Landing: on_ground=1 at a tick in FALL → one LAND cycle with land_pulse=1 and count_rst=1, then GROUNDED with Count=0.
  - A press 2 ticks before landing → jump taken on the first post-land tick.
  - A press 5 ticks before landing → expired, no jump.
- RESET asserted mid-JUMP between clock edges → outputs go to reset values immediately without waiting for CLK; Count=0 after next CLK; no spurious jump after release.
